// File: rtl/vctr_fetch.sv
// -----------------------------------------------------------------------------
// vctr_fetch
//   Buffers test-vector addresses coming from the driver, fetches each vector
//   word over an Avalon-style master read port and pushes the returned word
//   into the downstream vector FIFO. One read is outstanding at most.
//
// Ports
//   clk                 in   1   single clock, rising edge
//   reset               in   1   asynchronous, active-low reset
//   addr_fifo_din       in   32  vector address from driver
//   addr_fifo_wr        in   1   push addr_fifo_din (one word per cycle)
//   addr_fifo_full      out  1   address FIFO full
//   addr_fifo_rd        out  1   one-cycle pulse per popped address
//   words_in_addr_fifo  out  16  address FIFO occupancy, zero-extended
//   master_addr         out  32  read address
//   master_rd           out  1   read request, held until accepted
//   master_waitrequest  in   1   slave stall
//   master_data_in      in   32  read data
//   master_data_in_val  in   1   read data valid strobe
//   vctr_fifo_din       out  32  fetched vector word
//   vctr_fifo_wr        out  1   one-cycle push into vector FIFO
//   vctr_fifo_full      in   1   vector FIFO full, sampled only in IDLE
//   rd_timeout_err      out  1   sticky read-timeout flag
//   clr_err             in   1   synchronous clear of rd_timeout_err
//
// Handshakes: addr_fifo_wr, addr_fifo_rd, vctr_fifo_wr and master_data_in_val
// are single-cycle strobes carrying one word each. master_rd is a request that
// stays high with a stable master_addr until the rising edge on which
// master_waitrequest is low; that edge is the accept. Data returns later as a
// master_data_in_val strobe and is only honoured in WAIT.
// The FSM state is the internal signal `state` (state_t) for checkers to bind.
// -----------------------------------------------------------------------------
module vctr_fetch #(
   parameter int AFIFO_DEPTH = 16,
   parameter int RD_TIMEOUT  = 255
) (
   input  logic        clk,
   input  logic        reset,
   input  logic [31:0] addr_fifo_din,
   input  logic        addr_fifo_wr,
   output logic        addr_fifo_full,
   output logic        addr_fifo_rd,
   output logic [15:0] words_in_addr_fifo,
   output logic [31:0] master_addr,
   output logic        master_rd,
   input  logic        master_waitrequest,
   input  logic [31:0] master_data_in,
   input  logic        master_data_in_val,
   output logic [31:0] vctr_fifo_din,
   output logic        vctr_fifo_wr,
   input  logic        vctr_fifo_full,
   output logic        rd_timeout_err,
   input  logic        clr_err
);

   localparam int          AW       = $clog2(AFIFO_DEPTH);
   localparam logic [AW:0] FULL_CNT = (AW+1)'(AFIFO_DEPTH);
   localparam logic [15:0] TMO_LAST = 16'(RD_TIMEOUT - 1);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      REQ  = 2'd1,
      WAIT = 2'd2
   } state_t;

   state_t      state, state_d;

   logic [31:0] mem [AFIFO_DEPTH];
   logic [AW:0] wr_ptr, rd_ptr, count;
   logic        push, pop;

   logic [15:0] tmo_cnt, tmo_cnt_d;
   logic [31:0] master_addr_d, vctr_fifo_din_d;
   logic        master_rd_d, addr_fifo_rd_d, vctr_fifo_wr_d, rd_timeout_err_d;

   assign addr_fifo_full     = (count == FULL_CNT);
   assign words_in_addr_fifo = {{(15-AW){1'b0}}, count};

   // A vector push issued on the previous edge is not yet reflected in
   // vctr_fifo_full, so IDLE waits one cycle after a push before trusting it.
   assign pop  = (state == IDLE) && (count != '0) && !vctr_fifo_full && !vctr_fifo_wr;
   // A push into a full FIFO is accepted when a pop frees a slot on the same edge.
   assign push = addr_fifo_wr && (!addr_fifo_full || pop);

   // ---------------- address FIFO ----------------
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (push) wr_ptr <= wr_ptr + 1'b1;
         if (pop)  rd_ptr <= rd_ptr + 1'b1;
         case ({push, pop})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: count <= count;
         endcase
      end
   end

   // When full, push and pop address the same slot; the pop captures the old
   // word into master_addr on the same edge the new word is written.
   always_ff @(posedge clk) begin
      if (push) mem[wr_ptr[AW-1:0]] <= addr_fifo_din;
   end

   // ---------------- fetch FSM: next state / next outputs ----------------
   always_comb begin
      state_d          = state;
      tmo_cnt_d        = tmo_cnt;
      master_addr_d    = master_addr;
      master_rd_d      = master_rd;
      vctr_fifo_din_d  = vctr_fifo_din;
      addr_fifo_rd_d   = 1'b0;
      vctr_fifo_wr_d   = 1'b0;
      rd_timeout_err_d = rd_timeout_err & ~clr_err;

      case (state)
         IDLE: begin
            if (pop) begin
               master_addr_d  = mem[rd_ptr[AW-1:0]];
               master_rd_d    = 1'b1;
               addr_fifo_rd_d = 1'b1;
               state_d        = REQ;
            end
         end
         REQ: begin
            if (!master_waitrequest) begin
               master_rd_d = 1'b0;
               tmo_cnt_d   = '0;
               state_d     = WAIT;
            end
         end
         WAIT: begin
            if (master_data_in_val) begin
               vctr_fifo_din_d = master_data_in;
               vctr_fifo_wr_d  = 1'b1;
               tmo_cnt_d       = '0;
               state_d         = IDLE;
            end else if (tmo_cnt == TMO_LAST) begin
               // RD_TIMEOUT-th WAIT cycle without data: the vector is dropped.
               rd_timeout_err_d = 1'b1;
               tmo_cnt_d        = '0;
               state_d          = IDLE;
            end else begin
               tmo_cnt_d = tmo_cnt + 16'd1;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   // ---------------- fetch FSM: registers ----------------
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state          <= IDLE;
         tmo_cnt        <= '0;
         master_addr    <= '0;
         master_rd      <= 1'b0;
         vctr_fifo_din  <= '0;
         addr_fifo_rd   <= 1'b0;
         vctr_fifo_wr   <= 1'b0;
         rd_timeout_err <= 1'b0;
      end else begin
         state          <= state_d;
         tmo_cnt        <= tmo_cnt_d;
         master_addr    <= master_addr_d;
         master_rd      <= master_rd_d;
         vctr_fifo_din  <= vctr_fifo_din_d;
         addr_fifo_rd   <= addr_fifo_rd_d;
         vctr_fifo_wr   <= vctr_fifo_wr_d;
         rd_timeout_err <= rd_timeout_err_d;
      end
   end

endmodule

// File: tb/tb_vctr_fetch.sv
// -----------------------------------------------------------------------------
// tb_vctr_fetch
//   Self-checking bench for vctr_fetch (AFIFO_DEPTH=16, RD_TIMEOUT=8).
//   A bench-side slave answers reads with data = address ^ KEY; the model keeps
//   the expected vector words in exp_q in the order addresses were accepted.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_vctr_fetch;

   localparam int          DEPTH = 16;
   localparam int          TMO   = 8;
   localparam logic [31:0] KEY   = 32'hA5A5_A5A5;

   // ---------------- clock / reset ----------------
   logic clk;
   logic reset;
   initial clk = 1'b0;
   always #5 clk = ~clk;

   // ---------------- DUT signals ----------------
   logic [31:0] addr_fifo_din;
   logic        addr_fifo_wr;
   logic        addr_fifo_full;
   logic        addr_fifo_rd;
   logic [15:0] words_in_addr_fifo;
   logic [31:0] master_addr;
   logic        master_rd;
   logic        master_waitrequest;
   logic [31:0] master_data_in;
   logic        master_data_in_val;
   logic [31:0] vctr_fifo_din;
   logic        vctr_fifo_wr;
   logic        vctr_fifo_full;
   logic        rd_timeout_err;
   logic        clr_err;

   vctr_fetch #(.AFIFO_DEPTH(DEPTH), .RD_TIMEOUT(TMO)) dut (
      .clk                (clk),
      .reset              (reset),
      .addr_fifo_din      (addr_fifo_din),
      .addr_fifo_wr       (addr_fifo_wr),
      .addr_fifo_full     (addr_fifo_full),
      .addr_fifo_rd       (addr_fifo_rd),
      .words_in_addr_fifo (words_in_addr_fifo),
      .master_addr        (master_addr),
      .master_rd          (master_rd),
      .master_waitrequest (master_waitrequest),
      .master_data_in     (master_data_in),
      .master_data_in_val (master_data_in_val),
      .vctr_fifo_din      (vctr_fifo_din),
      .vctr_fifo_wr       (vctr_fifo_wr),
      .vctr_fifo_full     (vctr_fifo_full),
      .rd_timeout_err     (rd_timeout_err),
      .clr_err            (clr_err)
   );

   // ---------------- scoreboard state ----------------
   int          checks;
   int          failures;
   logic [31:0] exp_q[$];
   logic [31:0] got_q[$];
   int          rd_pulses;
   int          reads;
   bit          rd_prev;

   // slave behaviour knobs
   int slv_wait;
   int slv_lat;
   bit slv_no_valid;
   bit slv_rand;

   // ---------------- bench-side read slave ----------------
   initial begin
      logic [31:0] a;
      int          w;
      int          l;
      master_waitrequest = 1'b1;
      master_data_in_val = 1'b0;
      master_data_in     = '0;
      forever begin
         @(negedge clk);
         master_data_in_val = 1'b0;
         if (master_rd) begin
            a = master_addr;
            w = slv_rand ? int'($urandom_range(0, 3)) : slv_wait;
            l = slv_rand ? int'($urandom_range(1, 4)) : slv_lat;
            for (int i = 0; i < w; i++) begin
               master_waitrequest = 1'b1;
               @(negedge clk);
            end
            master_waitrequest = 1'b0;
            @(negedge clk);
            master_waitrequest = 1'b1;
            if (!slv_no_valid) begin
               for (int i = 1; i < l; i++) @(negedge clk);
               master_data_in     = a ^ KEY;
               master_data_in_val = 1'b1;
            end
         end
      end
   end

   // ---------------- monitor ----------------
   initial begin
      rd_pulses = 0;
      reads     = 0;
      rd_prev   = 1'b0;
      forever begin
         @(negedge clk);
         if (vctr_fifo_wr) got_q.push_back(vctr_fifo_din);
         if (addr_fifo_rd) rd_pulses++;
         if (master_rd && !rd_prev) reads++;
         rd_prev = master_rd;
      end
   end

   // ---------------- driver tasks ----------------
   function automatic logic [84:0] all_outs();
      return {addr_fifo_full, addr_fifo_rd, words_in_addr_fifo, master_addr, master_rd,
              vctr_fifo_din, vctr_fifo_wr, rd_timeout_err};
   endfunction

   task automatic drive_push(input logic [31:0] a);
      addr_fifo_din = a;
      addr_fifo_wr  = 1'b1;
      @(negedge clk);
      addr_fifo_wr  = 1'b0;
   endtask

   task automatic wait_got(input int n, input int budget, output bit ok);
      ok = 1'b0;
      for (int i = 0; i < budget && !ok; i++) begin
         @(negedge clk);
         #1;
         ok = (got_q.size() >= n);
      end
   endtask

   task automatic wait_master_rd(output bit found);
      found = 1'b0;
      for (int i = 0; i < 20 && !found; i++) begin
         @(negedge clk);
         found = master_rd;
      end
   endtask

   // ---------------- tests ----------------
   task automatic test_reset();
      reset = 1'b0;
      repeat (3) @(negedge clk);
      checks++;
      if (all_outs() !== '0) begin
         failures++;
         $display("FAIL reset_outs: got %h expected 0", all_outs());
      end
      reset = 1'b1;
      repeat (2) @(negedge clk);
      checks++;
      if (all_outs() !== '0) begin
         failures++;
         $display("FAIL reset_idle: got %h expected 0", all_outs());
      end
   endtask

   task automatic test_basic();
      int base_got;
      int base_rd;
      bit ok;
      logic [31:0] e;
      slv_rand = 0; slv_wait = 0; slv_lat = 2; slv_no_valid = 0;
      vctr_fifo_full = 1'b0;
      base_got = got_q.size();
      base_rd  = rd_pulses;
      for (int i = 0; i < 3; i++) begin
         drive_push(32'h100 + 32'(4 * i));
         exp_q.push_back((32'h100 + 32'(4 * i)) ^ KEY);
      end
      wait_got(base_got + 3, 100, ok);
      checks++;
      if (!ok) begin
         failures++;
         $display("FAIL basic_timeout: got %0d pushes expected 3", got_q.size() - base_got);
      end
      for (int i = 0; i < 3 && ok; i++) begin
         e = exp_q.pop_front();
         checks++;
         if (got_q[base_got + i] !== e) begin
            failures++;
            $display("FAIL basic_data[%0d]: got %h expected %h", i, got_q[base_got + i], e);
         end
      end
      checks++;
      if (rd_pulses - base_rd !== 3) begin
         failures++;
         $display("FAIL basic_rd_pulses: got %0d expected 3", rd_pulses - base_rd);
      end
      checks++;
      if (words_in_addr_fifo !== 16'd0) begin
         failures++;
         $display("FAIL basic_count: got %0d expected 0", words_in_addr_fifo);
      end
      exp_q.delete();
   endtask

   task automatic test_waitreq();
      int base_got;
      int base_reads;
      int bad;
      bit found;
      bit ok;
      logic [31:0] a;
      slv_rand = 0; slv_wait = 5; slv_lat = 1; slv_no_valid = 0;
      a = $urandom;
      base_got   = got_q.size();
      base_reads = reads;
      drive_push(a);
      wait_master_rd(found);
      checks++;
      if (!found) begin
         failures++;
         $display("FAIL waitreq_no_rd: master_rd got 0 expected 1");
      end
      bad = 0;
      for (int i = 0; i < 6; i++) begin
         if (!(master_rd === 1'b1 && master_addr === a)) bad++;
         @(negedge clk);
      end
      checks++;
      if (bad != 0) begin
         failures++;
         $display("FAIL waitreq_hold: %0d unstable cycles expected 0 (addr %h)", bad, a);
      end
      checks++;
      if (master_rd !== 1'b0) begin
         failures++;
         $display("FAIL waitreq_release: master_rd got %b expected 0", master_rd);
      end
      wait_got(base_got + 1, 50, ok);
      checks++;
      if (!ok || got_q[base_got] !== (a ^ KEY)) begin
         failures++;
         $display("FAIL waitreq_data: got %h expected %h", ok ? got_q[base_got] : 32'hx, a ^ KEY);
      end
      checks++;
      if (reads - base_reads !== 1) begin
         failures++;
         $display("FAIL waitreq_reads: got %0d expected 1", reads - base_reads);
      end
   endtask

   // One timeout with clr_err low, a normal fetch, then a timeout with clr_err
   // held high so the set and the clear collide on the same edge.
   task automatic test_timeout();
      int base_got;
      bit found;
      bit ok;
      logic [31:0] b;
      slv_rand = 0; slv_wait = 0; slv_lat = 1; slv_no_valid = 1;
      for (int pass = 0; pass < 2; pass++) begin
         base_got = got_q.size();
         clr_err  = (pass == 1);
         drive_push(32'h200 + 32'(pass));
         wait_master_rd(found);
         checks++;
         if (!found) begin
            failures++;
            $display("FAIL timeout_no_rd[%0d]: master_rd got 0 expected 1", pass);
         end
         repeat (TMO) @(negedge clk);
         checks++;
         if (rd_timeout_err !== 1'b0) begin
            failures++;
            $display("FAIL timeout_early[%0d]: err got %b expected 0", pass, rd_timeout_err);
         end
         @(negedge clk);
         checks++;
         if (rd_timeout_err !== 1'b1) begin
            failures++;
            $display("FAIL timeout_set[%0d]: err got %b expected 1", pass, rd_timeout_err);
         end
         clr_err = 1'b0;
         checks++;
         if (got_q.size() !== base_got) begin
            failures++;
            $display("FAIL timeout_push[%0d]: got %0d pushes expected 0", pass, got_q.size() - base_got);
         end
         if (pass == 0) begin
            slv_no_valid = 0;
            b = $urandom;
            drive_push(b);
            wait_got(base_got + 1, 50, ok);
            checks++;
            if (!ok || got_q[base_got] !== (b ^ KEY)) begin
               failures++;
               $display("FAIL timeout_next_data: got %h expected %h", ok ? got_q[base_got] : 32'hx, b ^ KEY);
            end
            checks++;
            if (rd_timeout_err !== 1'b1) begin
               failures++;
               $display("FAIL timeout_sticky: err got %b expected 1", rd_timeout_err);
            end
            slv_no_valid = 1;
         end
      end
      @(negedge clk);
      checks++;
      if (rd_timeout_err !== 1'b1) begin
         failures++;
         $display("FAIL timeout_set_wins: err got %b expected 1", rd_timeout_err);
      end
      clr_err = 1'b1;
      @(negedge clk);
      clr_err = 1'b0;
      checks++;
      if (rd_timeout_err !== 1'b0) begin
         failures++;
         $display("FAIL timeout_clr: err got %b expected 0", rd_timeout_err);
      end
      slv_no_valid = 0;
   endtask

   task automatic test_random();
      int base_got;
      int n;
      bit ok;
      logic [31:0] a;
      logic [31:0] e;
      slv_rand = 1; slv_no_valid = 0;
      vctr_fifo_full = 1'b0;
      base_got = got_q.size();
      n = $urandom_range(5, 12);
      for (int i = 0; i < n; i++) begin
         a = $urandom;
         drive_push(a);
         exp_q.push_back(a ^ KEY);
         repeat ($urandom_range(0, 3)) @(negedge clk);
      end
      wait_got(base_got + n, 400, ok);
      checks++;
      if (!ok) begin
         failures++;
         $display("FAIL random_timeout: got %0d pushes expected %0d", got_q.size() - base_got, n);
      end
      for (int i = 0; i < n && ok; i++) begin
         e = exp_q.pop_front();
         checks++;
         if (got_q[base_got + i] !== e) begin
            failures++;
            $display("FAIL random_data[%0d]: got %h expected %h", i, got_q[base_got + i], e);
         end
      end
      exp_q.delete();
      slv_rand = 0;
   endtask

   task automatic test_full_drop();
      int model_cnt;
      int base_reads;
      bit rd_seen;
      logic [31:0] a;
      vctr_fifo_full = 1'b1;
      model_cnt  = 0;
      rd_seen    = 1'b0;
      base_reads = reads;
      exp_q.delete();
      for (int i = 0; i < DEPTH + 1; i++) begin
         a = $urandom;
         drive_push(a);
         if (model_cnt < DEPTH) begin
            model_cnt++;
            exp_q.push_back(a ^ KEY);
         end
         rd_seen = rd_seen | master_rd;
         if (i == DEPTH - 2) begin
            checks++;
            if (addr_fifo_full !== 1'b0) begin
               failures++;
               $display("FAIL full_early: full got %b expected 0", addr_fifo_full);
            end
         end
         if (i == DEPTH - 1) begin
            checks++;
            if (addr_fifo_full !== 1'b1) begin
               failures++;
               $display("FAIL full_set: full got %b expected 1", addr_fifo_full);
            end
         end
      end
      checks++;
      if (words_in_addr_fifo !== 16'(model_cnt) || addr_fifo_full !== 1'b1) begin
         failures++;
         $display("FAIL full_drop: count got %0d full %b expected %0d full 1",
                  words_in_addr_fifo, addr_fifo_full, model_cnt);
      end
      checks++;
      if (rd_seen !== 1'b0 || reads != base_reads) begin
         failures++;
         $display("FAIL full_no_read: master_rd seen %b expected 0", rd_seen);
      end
   endtask

   // Continues from the full FIFO left by test_full_drop.
   task automatic test_push_pop_full();
      int base_got;
      int n;
      bit ok;
      logic [31:0] a;
      logic [31:0] e;
      slv_rand = 0; slv_wait = 0; slv_lat = 1; slv_no_valid = 0;
      base_got = got_q.size();
      a = $urandom;
      vctr_fifo_full = 1'b0;
      addr_fifo_din  = a;
      addr_fifo_wr   = 1'b1;
      @(negedge clk);
      addr_fifo_wr   = 1'b0;
      exp_q.push_back(a ^ KEY);
      checks++;
      if (addr_fifo_rd !== 1'b1 || words_in_addr_fifo !== 16'(DEPTH) || addr_fifo_full !== 1'b1) begin
         failures++;
         $display("FAIL pushpop_full: rd %b count %0d full %b expected rd 1 count %0d full 1",
                  addr_fifo_rd, words_in_addr_fifo, addr_fifo_full, DEPTH);
      end
      n = exp_q.size();
      wait_got(base_got + n, 600, ok);
      checks++;
      if (!ok) begin
         failures++;
         $display("FAIL pushpop_timeout: got %0d pushes expected %0d", got_q.size() - base_got, n);
      end
      for (int i = 0; i < n && ok; i++) begin
         e = exp_q.pop_front();
         checks++;
         if (got_q[base_got + i] !== e) begin
            failures++;
            $display("FAIL pushpop_order[%0d]: got %h expected %h", i, got_q[base_got + i], e);
         end
      end
      checks++;
      if (words_in_addr_fifo !== 16'd0) begin
         failures++;
         $display("FAIL pushpop_drained: count got %0d expected 0", words_in_addr_fifo);
      end
      exp_q.delete();
   endtask

   task automatic test_reset_mid();
      int base_got;
      bit found;
      slv_rand = 0; slv_wait = 0; slv_lat = 6; slv_no_valid = 0;
      vctr_fifo_full = 1'b0;
      base_got = got_q.size();
      drive_push($urandom);
      wait_master_rd(found);
      checks++;
      if (!found) begin
         failures++;
         $display("FAIL rstmid_no_rd: master_rd got 0 expected 1");
      end
      repeat (3) @(negedge clk);
      reset = 1'b0;
      #1;
      checks++;
      if (all_outs() !== '0) begin
         failures++;
         $display("FAIL rstmid_async: got %h expected 0", all_outs());
      end
      repeat (2) @(negedge clk);
      reset = 1'b1;
      repeat (8) @(negedge clk);
      #1;
      checks++;
      if (got_q.size() !== base_got) begin
         failures++;
         $display("FAIL rstmid_push: got %0d pushes expected 0", got_q.size() - base_got);
      end
      checks++;
      if (all_outs() !== '0) begin
         failures++;
         $display("FAIL rstmid_outs: got %h expected 0", all_outs());
      end
   endtask

   // ---------------- main sequence ----------------
   initial begin
      checks         = 0;
      failures       = 0;
      reset          = 1'b0;
      addr_fifo_din  = '0;
      addr_fifo_wr   = 1'b0;
      vctr_fifo_full = 1'b0;
      clr_err        = 1'b0;
      slv_wait       = 0;
      slv_lat        = 1;
      slv_no_valid   = 0;
      slv_rand       = 0;
      @(negedge clk);
      test_reset();
      test_basic();
      test_waitreq();
      test_timeout();
      test_random();
      test_full_drop();
      test_push_pop_full();
      test_reset_mid();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   // Global watchdog.
   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached, checks=%0d failures=%0d", checks, failures);
      $fatal(1, "watchdog");
   end

endmodule
